torus_result_collector: RTL

Sampling collector on the receiving end of the CGRA torus result lanes. On a programmed cycle schedule it captures the four 16-bit row-0 result lanes (`data_out0..3` of the torus array) into an internal FIFO. It then serializes them, lane 0 first, onto a 16-bit valid/ready stream toward the host/DMA side. It sits between the torus array top and the host interface and is the reader matching the array's output drive.

---
 rtl/torus_result_collector.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/torus_result_collector.sv
// -----------------------------------------------------------------------------
// torus_result_collector
//
// Captures the four row-0 result lanes of the CGRA torus array on a programmed
// cycle schedule, buffers each capture as one 4-lane FIFO entry and serializes
// the entries, lane 0 first, onto a DW-bit valid/ready stream for the host/DMA.
//
// Schedule: a start accepted in cycle T takes sample k (k = 0..N-1) in cycle
// T+1+offset+k*stride. A stride of 0 is treated as 1.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   start          one-cycle run request, honoured only while idle
//   cfg_offset     cycles from start to the first sample (latched on start)
//   cfg_stride     cycles between samples, 0 behaves as 1 (latched on start)
//   cfg_samples    number of samples N (latched on start)
//   data_in0..3    torus result lanes 0..3
//   m_data         stream word
//   m_valid        stream word valid
//   m_ready        downstream ready
//   m_last         marks the lane-3 word of the final emitted entry of a run
//   busy           run in progress (from T+1 through the done cycle)
//   done           one-cycle completion pulse
//   overflow       sticky per run: a sample was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module torus_result_collector #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   cfg_offset,
    input  logic [7:0]    cfg_stride,
    input  logic [15:0]   cfg_samples,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    input  logic [DW-1:0] data_in2,
    input  logic [DW-1:0] data_in3,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 4 * DW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Lane packing: entry bits [gi*DW +: DW] hold lane gi, both on the way in
    // (capture) and on the way out (serializer lane select).
    // -------------------------------------------------------------------------
    logic [DW-1:0] lane_in [4];
    logic [DW-1:0] ser_lane [4];
    logic [EW-1:0] sample_word;
    logic [EW-1:0] ser_entry_reg;

    assign lane_in[0] = data_in0;
    assign lane_in[1] = data_in1;
    assign lane_in[2] = data_in2;
    assign lane_in[3] = data_in3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign sample_word[gi*DW +: DW] = lane_in[gi];
            assign ser_lane[gi]             = ser_entry_reg[gi*DW +: DW];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t      state_reg,      state_next;
    logic [15:0] wait_cnt_reg,   wait_cnt_next;
    logic [7:0]  stride_m1_reg,  stride_m1_next;   // effective stride minus one
    logic [7:0]  stride_cnt_reg, stride_cnt_next;
    logic [15:0] left_reg,       left_next;        // samples still to take
    logic        overflow_reg,   overflow_next;
    logic        take;                              // a sample is due this cycle
    logic        done_int;

    // -------------------------------------------------------------------------
    // Sample FIFO: pointers carry one extra wrap bit to tell full from empty.
    // -------------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_wr;
    logic          fifo_pop;

    // -------------------------------------------------------------------------
    // Serializer
    // -------------------------------------------------------------------------
    logic       ser_valid_reg;
    logic [1:0] lane_reg;
    logic       fire;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign fire = ser_valid_reg && m_ready;

    // Refill when the serializer is empty, or as lane 3 leaves, so consecutive
    // entries stream back-to-back.
    assign fifo_pop = !fifo_empty &&
                      (!ser_valid_reg || (fire && (lane_reg == 2'd3)));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_wr = take && (!fifo_full || fifo_pop);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        stride_m1_next  = stride_m1_reg;
        stride_cnt_next = stride_cnt_reg;
        left_next       = left_reg;
        overflow_next   = overflow_reg;
        take            = 1'b0;
        done_int        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    wait_cnt_next  = cfg_offset;
                    stride_m1_next = (cfg_stride == 8'd0) ? 8'd0 : (cfg_stride - 8'd1);
                    left_next      = cfg_samples;
                    overflow_next  = 1'b0;
                    state_next     = (cfg_samples == 16'd0) ? S_DRAIN : S_WAIT;
                end
            end

            S_WAIT: begin
                if (wait_cnt_reg == 16'd0) begin
                    take            = 1'b1;
                    left_next       = left_reg - 16'd1;
                    stride_cnt_next = stride_m1_reg;
                    state_next      = (left_reg == 16'd1) ? S_DRAIN : S_SAMPLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 16'd1;
                end
            end

            S_SAMPLE: begin
                if (stride_cnt_reg == 8'd0) begin
                    take            = 1'b1;
                    left_next       = left_reg - 16'd1;
                    stride_cnt_next = stride_m1_reg;
                    state_next      = (left_reg == 16'd1) ? S_DRAIN : S_SAMPLE;
                end else begin
                    stride_cnt_next = stride_cnt_reg - 8'd1;
                end
            end

            S_DRAIN: begin
                if (fifo_empty && !ser_valid_reg) begin
                    done_int   = 1'b1;
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A dropped sample still consumed its slot in the schedule above.
        if (take && fifo_full && !fifo_pop) begin
            overflow_next = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            wait_cnt_reg   <= '0;
            stride_m1_reg  <= '0;
            stride_cnt_reg <= '0;
            left_reg       <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            stride_m1_reg  <= stride_m1_next;
            stride_cnt_reg <= stride_cnt_next;
            left_reg       <= left_next;
            overflow_reg   <= overflow_next;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (no reset, so it can map onto block RAM) and pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= sample_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Serializer: the registered FIFO read lands directly in the entry holder.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_entry_reg <= '0;
            ser_valid_reg <= 1'b0;
            lane_reg      <= 2'd0;
        end else if (fifo_pop) begin
            ser_entry_reg <= mem[rd_ptr_reg[AW-1:0]];
            ser_valid_reg <= 1'b1;
            lane_reg      <= 2'd0;
        end else if (fire) begin
            if (lane_reg == 2'd3) begin
                ser_valid_reg <= 1'b0;
            end
            lane_reg <= lane_reg + 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The final word is lane 3 with nothing behind it: every sample has been
    // taken (DRAIN) and the FIFO is empty. Neither term can change while the
    // word is stalled, so m_last stays stable under backpressure.
    assign m_valid  = ser_valid_reg;
    assign m_data   = ser_lane[lane_reg];
    assign m_last   = ser_valid_reg && (lane_reg == 2'd3) && fifo_empty &&
                      (state_reg == S_DRAIN);
    assign busy     = (state_reg != S_IDLE);
    assign done     = done_int;
    assign overflow = overflow_reg;

endmodule
